mem_port_arbiter: RTL and testbench

//  Parametrised N-channel arbiter that merges pipeline memory requesters (D-side MEM stage,
//  I-side IF stage, later prefetch/DMA) onto one shared memory/L2 port. Each channel gets a
//  per-channel resp pulse that drops its stall. Fixed or round-robin priority, a registered

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: arbitration mode, FSM state and
// the 16-bit word / byte-mask aliases used by the LC-3b datapath.
package mem_port_arbiter_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} lc3b_arb_mode;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} lc3b_arb_state;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and shared-memory-side signals of the arbiter. The slave
// modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 16,
  parameter int DW  = 16
);
  logic [NCH-1:0]        ch_read;
  logic [NCH-1:0]        ch_write;
  logic [NCH*AW-1:0]     ch_addr;
  logic [NCH*DW-1:0]     ch_wdata;
  logic [NCH*DW/8-1:0]   ch_wmask;
  logic [NCH-1:0]        ch_resp;
  logic [DW-1:0]         ch_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [AW-1:0]         mem_address;
  logic [DW-1:0]         mem_wdata;
  logic [DW/8-1:0]       mem_byte_enable;
  logic                  mem_resp;
  logic [DW-1:0]         mem_rdata;

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, ch_wmask, mem_resp, mem_rdata,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, ch_wmask, mem_resp, mem_rdata,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection: lowest pending index (fixed) or first
// pending index at or after ptr, wrapping (round-robin).
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]              pend,
  input  logic [idx_width(NCH)-1:0]   ptr,
  input  lc3b_arb_mode                mode,
  output logic [idx_width(NCH)-1:0]   idx,
  output logic                        valid
);
  localparam int IW = idx_width(NCH);

  // Scan from the far end so the candidate closest to the search start wins.
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = |pend;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = (mode == ARB_RR) ? ((int'(ptr) + k) % NCH) : k;
      if (pend[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging pipeline memory requesters onto one shared port,
// with registered transaction hold, fixed/round-robin priority and watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int           NCH      = 2,
  parameter int           AW       = 16,
  parameter int           DW       = 16,
  parameter lc3b_arb_mode ARB_MODE = ARB_FIXED,
  parameter int           TMO_CYC  = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  mem_port_arbiter_if.slave          bus,
  output logic [idx_width(NCH)-1:0]  grant_idx,
  output logic                       busy,
  output logic                       tmo_err
);
  localparam int IW = idx_width(NCH);
  localparam int BW = DW / 8;
  localparam int TW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  lc3b_arb_state  state_reg, state_next;
  logic [NCH-1:0] pend;
  logic [IW-1:0]  win_idx;
  logic           win_valid;
  logic           grant_en;
  logic [IW-1:0]  rr_ptr_reg;
  logic [IW-1:0]  grant_reg;
  logic [AW-1:0]  hold_addr_reg;
  logic [DW-1:0]  hold_wdata_reg;
  logic [BW-1:0]  hold_wmask_reg;
  logic           hold_rd_reg;
  logic           hold_wr_reg;
  logic [TW-1:0]  tmo_cnt_reg;
  logic           tmo_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_pend
      assign pend[gi] = bus.ch_read[gi] | bus.ch_write[gi];
    end
  endgenerate

  arb_pick #(.NCH(NCH)) u_pick (
    .pend  (pend),
    .ptr   (rr_ptr_reg),
    .mode  (ARB_MODE),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign grant_en = (state_reg == ARB_IDLE) && win_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= ARB_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (win_valid)    state_next = ARB_BUSY;
      ARB_BUSY: if (bus.mem_resp) state_next = ARB_IDLE;
      default:                    state_next = ARB_IDLE;
    endcase
  end

  // A request with both read and write set is carried out as a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
      hold_wmask_reg <= '0;
      hold_rd_reg    <= 1'b0;
      hold_wr_reg    <= 1'b0;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
    end else if (grant_en) begin
      hold_addr_reg  <= bus.ch_addr[win_idx*AW +: AW];
      hold_wdata_reg <= bus.ch_wdata[win_idx*DW +: DW];
      hold_wmask_reg <= bus.ch_wmask[win_idx*BW +: BW];
      hold_wr_reg    <= bus.ch_write[win_idx];
      hold_rd_reg    <= bus.ch_read[win_idx] & ~bus.ch_write[win_idx];
      grant_reg      <= win_idx;
      if (ARB_MODE == ARB_RR)
        rr_ptr_reg <= (win_idx == IW'(NCH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Counter saturates at TMO_CYC; the flag stays set until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
    end else if ((state_reg == ARB_BUSY) && !bus.mem_resp) begin
      if ((TMO_CYC > 0) && (tmo_cnt_reg != TW'(TMO_CYC)))
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if ((TMO_CYC > 0) && (tmo_cnt_reg >= TW'(TMO_CYC - 1)))
        tmo_err_reg <= 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  always_comb begin
    busy                = (state_reg == ARB_BUSY);
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    bus.ch_resp         = '0;
    if (state_reg == ARB_BUSY) begin
      bus.mem_read        = hold_rd_reg;
      bus.mem_write       = hold_wr_reg;
      bus.mem_address     = hold_addr_reg;
      bus.mem_wdata       = hold_wdata_reg;
      bus.mem_byte_enable = hold_wmask_reg;
      // A flushed requester no longer sees its completion.
      if (bus.mem_resp) bus.ch_resp = pend & (NCH'(1) << grant_reg);
    end
  end

  assign bus.ch_rdata = bus.mem_rdata;
  assign grant_idx    = grant_reg;
  assign tmo_err      = tmo_err_reg;

  a_no_rdwr: assert property (@(posedge clk) disable iff (!reset_n)
                              ((bus.ch_read & bus.ch_write) == '0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a fixed-priority 2-channel instance (short watchdog)
// and a round-robin 4-channel instance driven from tables and sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NCH(2), .AW(16), .DW(16)) if_fix ();
  mem_port_arbiter_if #(.NCH(4), .AW(16), .DW(16)) if_rr ();

  logic [0:0] fix_grant;
  logic       fix_busy, fix_tmo;
  logic [1:0] rr_grant;
  logic       rr_busy, rr_tmo;

  mem_port_arbiter #(.NCH(2), .AW(16), .DW(16), .ARB_MODE(ARB_FIXED), .TMO_CYC(8)) u_fix (
    .clk(clk), .reset_n(reset_n), .bus(if_fix.slave),
    .grant_idx(fix_grant), .busy(fix_busy), .tmo_err(fix_tmo)
  );

  mem_port_arbiter #(.NCH(4), .AW(16), .DW(16), .ARB_MODE(ARB_RR), .TMO_CYC(255)) u_rr (
    .clk(clk), .reset_n(reset_n), .bus(if_rr.slave),
    .grant_idx(rr_grant), .busy(rr_busy), .tmo_err(rr_tmo)
  );

  typedef struct {
    logic [1:0] resp;
    lc3b_word   rdata;
  } exp_t;

  typedef struct {
    int            ch;
    bit            wr;
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
    int            lat;
    lc3b_word      rdata;
    bit            scramble;
    bit            flush;
    logic [1:0]    exp_resp;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[7];
  int   rr_order[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor for the fixed instance: every pulse must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    #3;
    if (if_fix.ch_resp !== 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", {30'd0, if_fix.ch_resp}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_resp", {30'd0, if_fix.ch_resp}, {30'd0, sb_e.resp});
        chk("sb_rdata", {16'd0, if_fix.ch_rdata}, {16'd0, sb_e.rdata});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  task automatic clr_inputs();
    if_fix.ch_read = '0; if_fix.ch_write = '0; if_fix.ch_addr = '0;
    if_fix.ch_wdata = '0; if_fix.ch_wmask = '0; if_fix.mem_resp = 1'b0; if_fix.mem_rdata = '0;
    if_rr.ch_read = '0; if_rr.ch_write = '0; if_rr.ch_addr = '0;
    if_rr.ch_wdata = '0; if_rr.ch_wmask = '0; if_rr.mem_resp = 1'b0; if_rr.mem_rdata = '0;
  endtask

  task automatic push_exp(input logic [1:0] resp, input lc3b_word rdata);
    exp_t e;
    e.resp  = resp;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  task automatic check_mem(input vec_t v, input string tag);
    chk({tag, "_busy"},  {31'd0, fix_busy}, 32'd1);
    chk({tag, "_grant"}, {31'd0, fix_grant}, v.ch);
    chk({tag, "_rd"},    {31'd0, if_fix.mem_read}, {31'd0, !v.wr});
    chk({tag, "_wr"},    {31'd0, if_fix.mem_write}, {31'd0, v.wr});
    chk({tag, "_addr"},  {16'd0, if_fix.mem_address}, {16'd0, v.addr});
    chk({tag, "_wdata"}, {16'd0, if_fix.mem_wdata}, {16'd0, v.wdata});
    chk({tag, "_be"},    {30'd0, if_fix.mem_byte_enable}, {30'd0, v.wmask});
  endtask

  task automatic scramble(input int ch);
    if_fix.ch_addr[ch*16 +: 16]  = 16'($urandom);
    if_fix.ch_wdata[ch*16 +: 16] = 16'($urandom);
    if_fix.ch_wmask[ch*2 +: 2]   = 2'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    @(negedge clk);
    if_fix.ch_read[v.ch]         = !v.wr;
    if_fix.ch_write[v.ch]        = v.wr;
    if_fix.ch_addr[v.ch*16 +: 16]  = v.addr;
    if_fix.ch_wdata[v.ch*16 +: 16] = v.wdata;
    if_fix.ch_wmask[v.ch*2 +: 2]   = v.wmask;
    if (v.exp_resp != 2'b00) push_exp(v.exp_resp, v.rdata);
    @(negedge clk);
    check_mem(v, tag);
    if (v.flush) begin
      if_fix.ch_read[v.ch]  = 1'b0;
      if_fix.ch_write[v.ch] = 1'b0;
    end
    if (v.scramble) scramble(v.ch);
    for (int k = 1; k < v.lat; k++) begin
      @(negedge clk);
      check_mem(v, tag);
      if (v.scramble) scramble(v.ch);
    end
    if_fix.mem_resp  = 1'b1;
    if_fix.mem_rdata = v.rdata;
    #3;
    chk({tag, "_ch_resp"}, {30'd0, if_fix.ch_resp}, {30'd0, v.exp_resp});
    @(negedge clk);
    if_fix.mem_resp = 1'b0;
    if_fix.ch_read  = '0;
    if_fix.ch_write = '0;
    chk({tag, "_idle_busy"}, {31'd0, fix_busy}, 32'd0);
    chk({tag, "_idle_mem"},  {30'd0, if_fix.mem_read, if_fix.mem_write}, 32'd0);
    $display("txn %s ch%0d %s addr=0x%04h lat=%0d resp=%b", tag, v.ch,
             v.wr ? "WR" : "RD", v.addr, v.lat, v.exp_resp);
  endtask

  initial begin
    //         ch wr addr      wdata     mask  lat rdata     scr  flush resp
    vecs[0] = '{0, 1'b0, 16'h1234, 16'h0000, 2'b11, 1, 16'hA5A5, 1'b0, 1'b0, 2'b01};
    vecs[1] = '{1, 1'b1, 16'h00FE, 16'h5A5A, 2'b11, 2, 16'h0BAD, 1'b0, 1'b0, 2'b10};
    vecs[2] = '{0, 1'b1, 16'h0040, 16'hBEEF, 2'b10, 3, 16'h1357, 1'b1, 1'b0, 2'b01};
    vecs[3] = '{1, 1'b0, 16'h2000, 16'h0000, 2'b11, 3, 16'h2468, 1'b0, 1'b1, 2'b00};
    vecs[4] = '{1, 1'b0, 16'hFFFF, 16'h0000, 2'b11, 1, 16'hFFFF, 1'b0, 1'b0, 2'b10};
    vecs[5] = '{0, 1'b1, 16'h0000, 16'h0001, 2'b01, 4, 16'h0000, 1'b1, 1'b0, 2'b01};
    vecs[6] = '{0, 1'b0, 16'h8001, 16'h0000, 2'b11, 1, 16'hC0DE, 1'b0, 1'b1, 2'b00};
    rr_order = '{0, 1, 2, 3, 0};

    // Reset with requests present: nothing may reach the memory port.
    clr_inputs();
    if_fix.ch_read = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, fix_busy}, 32'd0);
    chk("rst_mem",   {30'd0, if_fix.mem_read, if_fix.mem_write}, 32'd0);
    chk("rst_addr",  {16'd0, if_fix.mem_address}, 32'd0);
    chk("rst_resp",  {30'd0, if_fix.ch_resp}, 32'd0);
    chk("rst_grant", {31'd0, fix_grant}, 32'd0);
    chk("rst_tmo",   {31'd0, fix_tmo}, 32'd0);
    chk("rst_rr_busy", {31'd0, rr_busy}, 32'd0);
    if_fix.ch_read = '0;
    reset_n = 1'b1;

    // Simultaneous reads on a fixed-priority port: channel 0 first.
    @(negedge clk);
    if_fix.ch_read = 2'b11;
    if_fix.ch_addr = {16'h2000, 16'h1000};
    push_exp(2'b01, 16'h1111);
    push_exp(2'b10, 16'h2222);
    @(negedge clk);
    chk("fix0_busy",  {31'd0, fix_busy}, 32'd1);
    chk("fix0_grant", {31'd0, fix_grant}, 32'd0);
    chk("fix0_addr",  {16'd0, if_fix.mem_address}, 32'h1000);
    chk("fix0_rd",    {31'd0, if_fix.mem_read}, 32'd1);
    if_fix.mem_resp = 1'b1; if_fix.mem_rdata = 16'h1111;
    #3 chk("fix0_resp", {30'd0, if_fix.ch_resp}, 32'd1);
    @(negedge clk);
    if_fix.mem_resp = 1'b0; if_fix.ch_read[0] = 1'b0;
    chk("fix_gap_busy", {31'd0, fix_busy}, 32'd0);
    chk("fix_gap_rd",   {31'd0, if_fix.mem_read}, 32'd0);
    @(negedge clk);
    chk("fix1_grant", {31'd0, fix_grant}, 32'd1);
    chk("fix1_addr",  {16'd0, if_fix.mem_address}, 32'h2000);
    if_fix.mem_resp = 1'b1; if_fix.mem_rdata = 16'h2222;
    #3 chk("fix1_resp", {30'd0, if_fix.ch_resp}, 32'd2);
    @(negedge clk);
    if_fix.mem_resp = 1'b0; if_fix.ch_read = '0;
    chk("fix1_idle", {31'd0, fix_busy}, 32'd0);
    $display("txn fix_pair ch0@0x1000 then ch1@0x2000");

    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("vec_tmo_clear", {31'd0, fix_tmo}, 32'd0);

    // Watchdog: memory withholds completion past TMO_CYC=8 busy cycles.
    @(negedge clk);
    if_fix.ch_read[0] = 1'b1;
    if_fix.ch_addr[15:0] = 16'h0ABC;
    push_exp(2'b01, 16'h7777);
    @(negedge clk);
    chk("tmo_e0", {31'd0, fix_tmo}, 32'd0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk($sformatf("tmo_e%0d", n), {31'd0, fix_tmo}, (n >= 8) ? 32'd1 : 32'd0);
    end
    chk("tmo_still_busy", {31'd0, fix_busy}, 32'd1);
    if_fix.mem_resp = 1'b1; if_fix.mem_rdata = 16'h7777;
    #3 chk("tmo_late_resp", {30'd0, if_fix.ch_resp}, 32'd1);
    @(negedge clk);
    if_fix.mem_resp = 1'b0; if_fix.ch_read = '0;
    chk("tmo_idle", {31'd0, fix_busy}, 32'd0);
    @(negedge clk);
    chk("tmo_sticky", {31'd0, fix_tmo}, 32'd1);
    $display("txn watchdog ch0@0x0ABC resp after 9 busy cycles");

    // Round-robin over four continuously requesting channels.
    @(negedge clk);
    if_rr.ch_read = 4'hF;
    if_rr.ch_addr = {16'h3003, 16'h3002, 16'h3001, 16'h3000};
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_busy", n),  {31'd0, rr_busy}, 32'd1);
      chk($sformatf("rr%0d_grant", n), {30'd0, rr_grant}, rr_order[n]);
      chk($sformatf("rr%0d_addr", n),  {16'd0, if_rr.mem_address}, 32'h3000 + rr_order[n]);
      if_rr.mem_resp = 1'b1;
      if_rr.mem_rdata = 16'h5000 + 16'(rr_order[n]);
      #3;
      chk($sformatf("rr%0d_resp", n),  {28'd0, if_rr.ch_resp}, 32'd1 << rr_order[n]);
      chk($sformatf("rr%0d_rdata", n), {16'd0, if_rr.ch_rdata}, 32'h5000 + rr_order[n]);
      @(negedge clk);
      if_rr.mem_resp = 1'b0;
      chk($sformatf("rr%0d_idle", n),  {31'd0, rr_busy}, 32'd0);
      $display("txn rr%0d granted ch%0d", n, rr_order[n]);
    end

    // Reset while busy on channel 1: abandoned, then re-arbitrated from 0.
    @(negedge clk);
    chk("rstb_grant", {30'd0, rr_grant}, 32'd1);
    reset_n = 1'b0;
    if_rr.mem_resp = 1'b1;
    @(negedge clk);
    chk("rstb_busy",  {31'd0, rr_busy}, 32'd0);
    chk("rstb_mem",   {30'd0, if_rr.mem_read, if_rr.mem_write}, 32'd0);
    chk("rstb_resp",  {28'd0, if_rr.ch_resp}, 32'd0);
    chk("rstb_grant0", {30'd0, rr_grant}, 32'd0);
    chk("rstb_fix_tmo", {31'd0, fix_tmo}, 32'd0);
    if_rr.mem_resp = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstb_rearb_busy",  {31'd0, rr_busy}, 32'd1);
    chk("rstb_rearb_grant", {30'd0, rr_grant}, 32'd0);
    if_rr.mem_resp = 1'b1;
    #3 chk("rstb_rearb_resp", {28'd0, if_rr.ch_resp}, 32'd1);
    @(negedge clk);
    if_rr.mem_resp = 1'b0; if_rr.ch_read = '0;
    $display("txn reset_mid_busy rearbitrated to ch0");

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
